// File: rtl/wb_data_select.sv
// rtl/wb_data_select.sv - registered write-back data selector with two-entry skid buffer
module wb_data_select #(
    parameter int          DATA_W    = 32,
    parameter int          N_CH      = 11,
    parameter int          SEL_W     = 4,
    parameter int          CONST_CH  = 8,
    parameter int unsigned CONST_VAL = 227,
    parameter int          CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_CH*DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_bad,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err_sel,
    input  logic                   err_clr,
    output logic [CNT_W-1:0]       beat_cnt
);

    localparam logic [DATA_W-1:0] CONST_WORD = DATA_W'(CONST_VAL);

    // Encoding is {main_valid, skid_valid}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t              state, state_nx;
    logic                accept;
    logic [DATA_W-1:0]   pick_data;
    logic                pick_bad;
    logic                load_main_in, load_main_skid, load_skid;
    logic [DATA_W-1:0]   main_data, skid_data;
    logic [SEL_W-1:0]    main_ch, skid_ch;
    logic                main_bad, skid_bad;

    // in_ready comes straight from the state register, so out_ready never reaches it combinationally
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign out_data  = main_data;
    assign out_ch    = main_ch;
    assign out_bad   = main_bad;

    // Source select: constant channel overrides its slice, unmatched selectors give zero and bad
    always_comb begin
        pick_data = '0;
        pick_bad  = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            if (32'(sel) == k) begin
                pick_bad  = 1'b0;
                pick_data = (k == CONST_CH) ? CONST_WORD : data_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // Buffer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_nx;
    end

    // Next state and entry load strobes
    always_comb begin
        state_nx       = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx     = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && out_ready) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_nx  = FULL;
                    load_skid = 1'b1;
                end else if (out_ready) begin
                    state_nx = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_nx       = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // Main and skid entry storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_data <= '0;
            main_ch   <= '0;
            main_bad  <= 1'b0;
            skid_data <= '0;
            skid_ch   <= '0;
            skid_bad  <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_data <= pick_data;
                main_ch   <= sel;
                main_bad  <= pick_bad;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ch   <= skid_ch;
                main_bad  <= skid_bad;
            end
            if (load_skid) begin
                skid_data <= pick_data;
                skid_ch   <= sel;
                skid_bad  <= pick_bad;
            end
        end
    end

    // Sticky bad-selector flag; a bad accept beats a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                err_sel <= 1'b0;
        else if (accept && pick_bad) err_sel <= 1'b1;
        else if (err_clr)            err_sel <= 1'b0;
    end

    // Debug count of beats taken by the register file, wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    beat_cnt <= '0;
        else if (out_valid && out_ready) beat_cnt <= beat_cnt + 1'b1;
    end

endmodule

// File: tb/tb_wb_data_select.sv
// tb/tb_wb_data_select.sv - randomized queue-model bench for wb_data_select
module tb_wb_data_select;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [351:0]  data_in;
    logic [3:0]    sel;
    logic          in_valid, out_ready, err_clr;
    logic          in_ready, out_valid, out_bad, err_sel;
    logic [31:0]   out_data;
    logic [3:0]    out_ch;
    logic [15:0]   beat_cnt;
    logic          in_ready4, out_valid4, out_bad4, err_sel4;
    logic [31:0]   out_data4;
    logic [3:0]    out_ch4;
    logic [3:0]    beat_cnt4;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  ch;
        logic        bad;
    } beat_t;

    beat_t q[$];
    logic  err_m;
    int    cnt_m;
    int    total = 0;
    int    bad   = 0;
    beat_t first_a;

    always #5 clk = ~clk;

    wb_data_select dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_ch(out_ch), .out_bad(out_bad), .out_valid(out_valid),
        .out_ready(out_ready), .err_sel(err_sel), .err_clr(err_clr),
        .beat_cnt(beat_cnt)
    );

    wb_data_select #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
        .out_ch(out_ch4), .out_bad(out_bad4), .out_valid(out_valid4),
        .out_ready(out_ready), .err_sel(err_sel4), .err_clr(err_clr),
        .beat_cnt(beat_cnt4)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t ref_sel(input logic [3:0] s);
        beat_t b;
        int    si;
        si    = int'(s);
        b.ch  = s;
        b.bad = (si >= 11);
        if (si >= 11)     b.d = 32'd0;
        else if (si == 8) b.d = 32'd227;
        else              b.d = data_in[si*32 +: 32];
        return b;
    endfunction

    task automatic check_outputs();
        beat_t f;
        check_val("out_valid", out_valid, q.size() > 0);
        check_val("in_ready", in_ready, q.size() < 2);
        check_val("err_sel", err_sel, err_m);
        check_val("beat_cnt", beat_cnt, cnt_m % 65536);
        check_val("beat_cnt4", beat_cnt4, cnt_m % 16);
        check_val("out_valid4", out_valid4, q.size() > 0);
        check_val("in_ready4", in_ready4, q.size() < 2);
        check_val("err_sel4", err_sel4, err_m);
        if (q.size() > 0) begin
            f = q[0];
            check_val("out_data", out_data, f.d);
            check_val("out_ch", out_ch, f.ch);
            check_val("out_bad", out_bad, f.bad);
            check_val("out_data4", out_data4, f.d);
            check_val("out_ch4", out_ch4, f.ch);
            check_val("out_bad4", out_bad4, f.bad);
        end
    endtask

    task automatic randomize_data();
        for (int k = 0; k < 11; k++) data_in[k*32 +: 32] = $urandom;
    endtask

    // Called at a falling edge: check, drive, advance model, run one cycle
    task automatic step(input logic v, input logic [3:0] s, input logic r, input logic c);
        logic  acc, pop;
        beat_t b;
        check_outputs();
        in_valid  = v;
        sel       = s;
        out_ready = r;
        err_clr   = c;
        acc = v && (q.size() < 2);
        pop = r && (q.size() > 0);
        b   = ref_sel(s);
        if (pop) begin
            void'(q.pop_front());
            cnt_m++;
        end
        if (acc) q.push_back(b);
        if (acc && b.bad) err_m = 1'b1;
        else if (c)       err_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        err_m = 1'b0;
        cnt_m = 0;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 0; out_ready = 0; err_clr = 0; sel = '0; data_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_ch", out_ch, 0);
        check_val("rst_out_bad", out_bad, 0);
        check_outputs();
        reset_n = 1'b1;
        @(negedge clk);

        // sweep every legal channel
        for (int k = 0; k < 11; k++) data_in[k*32 +: 32] = 32'h1000_0000 + k;
        for (int k = 0; k < 11; k++) step(1'b1, 4'(k), 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        check_val("sweep_cnt", beat_cnt, 11);

        // out-of-range, clear pulse, then same-cycle set and clear
        step(1'b1, 4'd13, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b1, 4'd15, 1'b1, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        check_val("err_set_wins", err_sel, 1);

        // backpressure: A, B, C with downstream stalled
        randomize_data();
        first_a = ref_sel(4'd2);
        step(1'b1, 4'd2, 1'b0, 1'b1);
        step(1'b1, 4'd3, 1'b0, 1'b0);
        step(1'b1, 4'd4, 1'b0, 1'b0);
        step(1'b1, 4'd4, 1'b0, 1'b0);
        check_val("bp_in_ready", in_ready, 0);
        check_val("bp_hold_a", out_data, first_a.d);
        step(1'b1, 4'd4, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);

        // random stall traffic
        for (int i = 0; i < 1000; i++) begin
            randomize_data();
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
        end
        step(1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);

        // async reset while FULL
        step(1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd5, 1'b0, 1'b0);
        check_val("full_in_ready", in_ready, 0);
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_out_valid", out_valid, 0);
        check_val("arst_in_ready", in_ready, 1);
        check_val("arst_out_data", out_data, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        randomize_data();
        step(1'b1, 4'd6, 1'b1, 1'b0);
        check_val("post_rst_valid", out_valid, 1);

        // counter wrap with a 4-bit counter: 17 beats gives 1
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i % 11), 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        check_val("cnt4_wrap", beat_cnt4, 1);
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
